// File: rtl/alu_issue.sv
// ALU issue stage: decodes RV32I words into ALUControl/SrcA/SrcB and buffers them for execute.
// Optional stall counter port and logic are enabled by defining ALU_STALL_CNT_EN.
module alu_issue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      ALUControl,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic            out_illegal
`ifdef ALU_STALL_CNT_EN
  , output logic [31:0]   stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b11110;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00111;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_SLL  = 5'b00000;
  localparam logic [4:0] ALU_SRL  = 5'b10000;
  localparam logic [4:0] ALU_SRA  = 5'b11000;
  localparam logic [4:0] ALU_SLT  = 5'b11101;
  localparam logic [4:0] ALU_SLTU = 5'b11100;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [2:0]      funct3_s;
  logic            f7_zero_s, f7_alt_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_u_s, shamt_s;
  logic [4:0]      dec_ctl_s;
  logic [XLEN-1:0] dec_a_s, dec_b_s;
  logic            dec_ill_s;
  logic            unused_s;

  assign funct3_s  = in_instr[14:12];
  assign f7_zero_s = (in_instr[31:25] == 7'b0000000);
  assign f7_alt_s  = (in_instr[31:25] == 7'b0100000);
  assign imm_i_s   = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
  assign imm_s_s   = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign imm_u_s   = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'h000};
  assign shamt_s   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign unused_s  = ^in_instr[19:15];

  // Decode the incoming beat into ALU op, operands and an illegal flag
  always_comb begin
    dec_ctl_s = ALU_ADD;
    dec_a_s   = in_rs1;
    dec_b_s   = in_rs2;
    dec_ill_s = 1'b0;
    case (in_instr[6:0])
      OPC_OP: begin
        case (funct3_s)
          3'b000: begin
            dec_ctl_s = f7_alt_s ? ALU_SUB : ALU_ADD;
            dec_ill_s = ~(f7_zero_s | f7_alt_s);
          end
          3'b001: begin dec_ctl_s = ALU_SLL;  dec_ill_s = ~f7_zero_s; end
          3'b010: begin dec_ctl_s = ALU_SLT;  dec_ill_s = ~f7_zero_s; end
          3'b011: begin dec_ctl_s = ALU_SLTU; dec_ill_s = ~f7_zero_s; end
          3'b100: begin dec_ctl_s = ALU_XOR;  dec_ill_s = ~f7_zero_s; end
          3'b101: begin
            dec_ctl_s = f7_alt_s ? ALU_SRA : ALU_SRL;
            dec_ill_s = ~(f7_zero_s | f7_alt_s);
          end
          3'b110: begin dec_ctl_s = ALU_OR;   dec_ill_s = ~f7_zero_s; end
          3'b111: begin dec_ctl_s = ALU_AND;  dec_ill_s = ~f7_zero_s; end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec_b_s = imm_i_s;
        case (funct3_s)
          3'b000: dec_ctl_s = ALU_ADD;
          3'b010: dec_ctl_s = ALU_SLT;
          3'b011: dec_ctl_s = ALU_SLTU;
          3'b100: dec_ctl_s = ALU_XOR;
          3'b110: dec_ctl_s = ALU_OR;
          3'b111: dec_ctl_s = ALU_AND;
          3'b001: begin dec_ctl_s = ALU_SLL; dec_b_s = shamt_s; dec_ill_s = ~f7_zero_s; end
          3'b101: begin
            dec_ctl_s = f7_alt_s ? ALU_SRA : ALU_SRL;
            dec_b_s   = shamt_s;
            dec_ill_s = ~(f7_zero_s | f7_alt_s);
          end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OPC_LOAD:  dec_b_s = imm_i_s;
      OPC_STORE: dec_b_s = imm_s_s;
      OPC_BRANCH: begin
        case (funct3_s)
          3'b000, 3'b001: dec_ctl_s = ALU_SUB;
          3'b100, 3'b101: dec_ctl_s = ALU_SLT;
          3'b110, 3'b111: dec_ctl_s = ALU_SLTU;
          default:        dec_ill_s = 1'b1;
        endcase
      end
      OPC_LUI:   begin dec_a_s = {XLEN{1'b0}}; dec_b_s = imm_u_s; end
      OPC_AUIPC: begin dec_a_s = in_pc;        dec_b_s = imm_u_s; end
      default:   dec_ill_s = 1'b1;
    endcase
  end

  logic [4:0]      wr_ctl_s;
  logic [XLEN-1:0] wr_a_s, wr_b_s;

  // Illegal beats carry a canonical ADD 0,0 payload
  assign wr_ctl_s = dec_ill_s ? ALU_ADD : dec_ctl_s;
  assign wr_a_s   = dec_ill_s ? {XLEN{1'b0}} : dec_a_s;
  assign wr_b_s   = dec_ill_s ? {XLEN{1'b0}} : dec_b_s;

  logic [4:0]      ctl_mem_r [DEPTH];
  logic [XLEN-1:0] a_mem_r   [DEPTH];
  logic [XLEN-1:0] b_mem_r   [DEPTH];
  logic            ill_mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push_s, pop_s;

  assign in_ready  = (count_r < DEPTH_C);
  assign out_valid = (count_r != {CW{1'b0}});
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Buffer storage; contents are don't-care while the slot is not counted
  always_ff @(posedge clk) begin
    if (push_s) begin
      ctl_mem_r[wr_ptr_r] <= wr_ctl_s;
      a_mem_r[wr_ptr_r]   <= wr_a_s;
      b_mem_r[wr_ptr_r]   <= wr_b_s;
      ill_mem_r[wr_ptr_r] <= dec_ill_s;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation, forced to zero when the buffer is empty
  always_comb begin
    if (out_valid) begin
      ALUControl  = ctl_mem_r[rd_ptr_r];
      SrcA        = a_mem_r[rd_ptr_r];
      SrcB        = b_mem_r[rd_ptr_r];
      out_illegal = ill_mem_r[rd_ptr_r];
    end else begin
      ALUControl  = 5'b00000;
      SrcA        = {XLEN{1'b0}};
      SrcB        = {XLEN{1'b0}};
      out_illegal = 1'b0;
    end
  end

`ifdef ALU_STALL_CNT_EN
  logic [31:0] stall_cnt_r;
  assign stall_cnt = stall_cnt_r;

  // Saturating count of cycles where the head is held by execute
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (out_valid && !out_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected entries queued on acceptance, checked on pop.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
  logic        out_valid, out_ready;
  logic [4:0]  ALUControl;
  logic [31:0] SrcA, SrcB;
  logic        out_illegal;
`ifdef ALU_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  alu_issue #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .out_illegal(out_illegal)
`ifdef ALU_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
    logic        strict;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [4:0]  ctl;
    logic [31:0] a, b;
    logic        ill;
  } stim_t;

  exp_t        q[$];
  exp_t        nxt, mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        strict_lat = 1'b0;
  logic [31:0] exp_stall;
  logic [31:0] diff;
  stim_t       tbl[10];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference stall counter
  always @(posedge clk) begin
    if (reset) exp_stall <= 32'd0;
    else if (out_valid && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall <= exp_stall + 32'd1;
  end

  // Scoreboard monitor: pop/compare on output handshake, push on input handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("ctl", 64'(ALUControl), 64'(mon_e.ctl));
          check("srca", 64'(SrcA), 64'(mon_e.a));
          check("srcb", 64'(SrcB), 64'(mon_e.b));
          check("illegal", 64'(out_illegal), 64'(mon_e.ill));
          if (mon_e.strict) check("latency", 64'(cyc), 64'(mon_e.acc + 1));
        end
      end
      if (in_valid && in_ready) begin
        nxt.acc    = cyc;
        nxt.strict = strict_lat;
        q.push_back(nxt);
      end
    end
  end

  task automatic drive(input logic [31:0] instr, pc, rs1, rs2,
                       input logic [4:0] ctl, input logic [31:0] a, b, input logic ill);
    bit acc = 1'b0;
    int n = 0;
    in_instr = instr; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
    nxt.ctl = ctl; nxt.a = a; nxt.b = b; nxt.ill = ill;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drive_addi(input logic [11:0] imm);
    logic [31:0] ins;
    ins = {imm, 20'h00093};
    drive(ins, 32'h0, 32'h0, 32'h0, 5'b00010, 32'h0, {{20{imm[11]}}, imm}, 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h4030D093, 32'h0, 32'h80000080, 32'h7, 5'b11000, 32'h80000080, 32'h3, 1'b0};
    tbl[1] = '{32'h4230D093, 32'h0, 32'h80000080, 32'h7, 5'b00010, 32'h0, 32'h0, 1'b1};
    tbl[2] = '{32'h123450B7, 32'h0, 32'h55, 32'h66, 5'b00010, 32'h0, 32'h12345000, 1'b0};
    tbl[3] = '{32'hFFFFF097, 32'h100, 32'h55, 32'h66, 5'b00010, 32'h100, 32'hFFFFF000, 1'b0};
    tbl[4] = '{32'hFE20AE23, 32'h0, 32'h2000, 32'h9, 5'b00010, 32'h2000, 32'hFFFFFFFC, 1'b0};
    tbl[5] = '{32'h0020E063, 32'h0, 32'h11, 32'h22, 5'b11100, 32'h11, 32'h22, 1'b0};
    tbl[6] = '{32'h0020A063, 32'h0, 32'h11, 32'h22, 5'b00010, 32'h0, 32'h0, 1'b1};
    tbl[7] = '{32'h0000007F, 32'h0, 32'h11, 32'h22, 5'b00010, 32'h0, 32'h0, 1'b1};
    tbl[8] = '{32'h00812083, 32'h0, 32'h1000, 32'h3, 5'b00010, 32'h1000, 32'h8, 1'b0};
    tbl[9] = '{32'h0020B0B3, 32'h0, 32'h3, 32'h4, 5'b11100, 32'h3, 32'h4, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0; in_rs1 = 32'h0; in_rs2 = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ctl", 64'(ALUControl), 64'd0);
    check("rst_srca", 64'(SrcA), 64'd0);
    check("rst_srcb", 64'(SrcB), 64'd0);
`ifdef ALU_STALL_CNT_EN
    check("rst_stall", 64'(stall_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Single beats with execute always ready
    out_ready = 1'b1; strict_lat = 1'b1;
    drive(32'h002080B3, 32'h0, 32'd10, 32'd5, 5'b00010, 32'd10, 32'd5, 1'b0);
    check("add_visible", 64'(out_valid), 64'd1);
    drive(32'h402080B3, 32'h0, 32'd5, 32'd10, 5'b11110, 32'd5, 32'd10, 1'b0);
    diff = SrcA - SrcB;
    check("sub_result", 64'(diff), 64'hFFFFFFFB);
    check("sub_negative", 64'(diff[31]), 64'd1);
    for (int i = 0; i < 10; i++)
      drive(tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].ctl, tbl[i].a, tbl[i].b, tbl[i].ill);
    wait_drain();

    // Backpressure: two fill the buffer, the third waits
    out_ready = 1'b0; strict_lat = 1'b0;
    drive_addi(12'd1);
    drive_addi(12'd2);
    fork
      drive_addi(12'd3);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("full_in_ready", 64'(in_ready), 64'd0);
          check("hold_srcb", 64'(SrcB), 64'd1);
        end
`ifdef ALU_STALL_CNT_EN
        check("stall_cnt_held", 64'(stall_cnt), 64'd3);
        check("stall_cnt_model", 64'(stall_cnt), 64'(exp_stall));
`endif
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_in_ready", 64'(in_ready), 64'd0);
      end
    join
    wait_drain();

    // Steady push+pop with one entry in flight
    strict_lat = 1'b1;
    drive_addi(12'h010);
    for (int i = 1; i <= 8; i++) begin
      drive_addi(12'(12'h010 + i));
      check("pp_out_valid", 64'(out_valid), 64'd1);
      check("pp_in_ready", 64'(in_ready), 64'd1);
    end
    wait_drain();

    // Reset with two entries buffered
    out_ready = 1'b0; strict_lat = 1'b0;
    drive_addi(12'h7FF);
    drive_addi(12'h800);
    @(negedge clk);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_ctl", 64'(ALUControl), 64'd0);
    check("mid_rst_srcb", 64'(SrcB), 64'd0);
`ifdef ALU_STALL_CNT_EN
    check("mid_rst_stall", 64'(stall_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;

    out_ready = 1'b1; strict_lat = 1'b1;
    drive(32'h002080B3, 32'h0, 32'd7, 32'd9, 5'b00010, 32'd7, 32'd9, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
